// File: rtl/output_row_assembler.sv
// Reassembles narrow pixel beats into full rows with row index, frame-end flag
// and pixel sum, presented through a valid/ack holding register.
module output_row_assembler #(
  parameter int PIXEL_ARRAY_WIDTH  = 8,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int OUTPUT_BUS_WIDTH   = 2,
  parameter int PIXEL_BITS         = 8,
  localparam int BEATS     = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
  localparam int SUM_BITS  = PIXEL_BITS + $clog2(PIXEL_ARRAY_WIDTH),
  localparam int IDX_BITS  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1,
  localparam int BEAT_W    = OUTPUT_BUS_WIDTH * PIXEL_BITS,
  localparam int ROW_W     = PIXEL_ARRAY_WIDTH * PIXEL_BITS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                DATA_VALID,
  input  logic [BEAT_W-1:0]   DATA_IN,
  input  logic                ROW_ACK,
  output logic                ROW_VALID,
  output logic [ROW_W-1:0]    ROW_OUT,
  output logic [IDX_BITS-1:0] ROW_INDEX,
  output logic                FRAME_END,
  output logic [SUM_BITS-1:0] ROW_SUM,
  output logic                OVERRUN,
  output logic                TRUNCATED
);

  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  state_t                r_state;
  logic [BEAT_BITS-1:0]  r_beat;
  logic [ROW_W-1:0]      r_cap;
  logic [SUM_BITS-1:0]   r_sum;
  logic [IDX_BITS-1:0]   r_row;

  logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] w_lane;
  logic [BEAT_BITS-1:0]  w_cur_beat;
  logic [SUM_BITS-1:0]   w_beat_sum;
  logic [SUM_BITS-1:0]   w_sum_next;
  logic [ROW_W-1:0]      w_cap_next;
  logic                  w_done;
  logic                  w_free;
  logic [IDX_BITS-1:0]   w_row_next;

  genvar gj;
  generate
    for (gj = 0; gj < OUTPUT_BUS_WIDTH; gj++) begin : g_lane
      assign w_lane[gj] = DATA_IN[gj*PIXEL_BITS +: PIXEL_BITS];
    end
  endgenerate

  // A beat taken from IDLE is always beat 0, whatever r_beat holds.
  assign w_cur_beat = (r_state == S_IDLE) ? '0 : r_beat;
  assign w_done     = DATA_VALID && (w_cur_beat == BEAT_BITS'(BEATS - 1));
  assign w_free     = !ROW_VALID || ROW_ACK;
  assign w_row_next = (r_row == IDX_BITS'(PIXEL_ARRAY_HEIGHT - 1)) ? '0 : r_row + 1'b1;

  always_comb begin
    w_beat_sum = '0;
    for (int j = 0; j < OUTPUT_BUS_WIDTH; j++)
      w_beat_sum = w_beat_sum + SUM_BITS'(w_lane[j]);
  end

  always_comb begin
    w_cap_next = r_cap;
    w_cap_next[32'(w_cur_beat)*BEAT_W +: BEAT_W] = DATA_IN;
    w_sum_next = (w_cur_beat == '0) ? w_beat_sum : r_sum + w_beat_sum;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_cap     <= '0;
      r_sum     <= '0;
      r_row     <= '0;
      ROW_VALID <= 1'b0;
      ROW_OUT   <= '0;
      ROW_INDEX <= '0;
      FRAME_END <= 1'b0;
      ROW_SUM   <= '0;
      OVERRUN   <= 1'b0;
      TRUNCATED <= 1'b0;
    end else begin
      if (DATA_VALID) begin
        r_cap <= w_cap_next;
        r_sum <= w_sum_next;
      end

      if (w_done) begin
        r_state <= S_IDLE;
        r_beat  <= '0;
      end else if (DATA_VALID) begin
        r_state <= S_CAPTURE;
        r_beat  <= w_cur_beat + 1'b1;
      end else if (r_state == S_CAPTURE) begin
        // Gap mid-burst: the partial row is abandoned.
        r_state   <= S_IDLE;
        r_beat    <= '0;
        TRUNCATED <= 1'b1;
      end

      if (w_done) begin
        r_row <= w_row_next;
        if (w_free) begin
          ROW_VALID <= 1'b1;
          ROW_OUT   <= w_cap_next;
          ROW_SUM   <= w_sum_next;
          ROW_INDEX <= r_row;
          FRAME_END <= (r_row == IDX_BITS'(PIXEL_ARRAY_HEIGHT - 1));
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (ROW_ACK) begin
        ROW_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_output_row_assembler.sv
// Scoreboard bench for output_row_assembler: directed rows push expectations,
// a negedge monitor pops and compares each newly presented row.
module tb_output_row_assembler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DATA_VALID = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic        ROW_ACK = 1'b0;
  logic        ROW_VALID;
  logic [63:0] ROW_OUT;
  logic [1:0]  ROW_INDEX;
  logic        FRAME_END;
  logic [10:0] ROW_SUM;
  logic        OVERRUN;
  logic        TRUNCATED;

  output_row_assembler dut (
    .CLK(CLK), .RESET(RESET), .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN),
    .ROW_ACK(ROW_ACK), .ROW_VALID(ROW_VALID), .ROW_OUT(ROW_OUT),
    .ROW_INDEX(ROW_INDEX), .FRAME_END(FRAME_END), .ROW_SUM(ROW_SUM),
    .OVERRUN(OVERRUN), .TRUNCATED(TRUNCATED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] row;
    logic [1:0]  idx;
    logic        fe;
    logic [10:0] sum;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  bit   prev_consumed = 1'b1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int base);
    logic [63:0] r;
    for (int p = 0; p < 8; p++) r[p*8 +: 8] = 8'(base + p);
    return r;
  endfunction

  function automatic logic [10:0] sum_of(input logic [63:0] r);
    logic [10:0] s = '0;
    for (int p = 0; p < 8; p++) s = s + 11'(r[p*8 +: 8]);
    return s;
  endfunction

  task automatic expect_row(input logic [63:0] r, input logic [1:0] idx);
    exp_t e;
    e.row = r; e.idx = idx; e.fe = (idx == 2'd3); e.sum = sum_of(r);
    q.push_back(e);
  endtask

  // Drives BEATS consecutive beats; leaves DATA_VALID high afterwards.
  task automatic send_row(input logic [63:0] r, input bit ack_last);
    for (int k = 0; k < 4; k++) begin
      DATA_VALID = 1'b1;
      DATA_IN    = r[k*16 +: 16];
      if (k == 3 && ack_last) ROW_ACK = 1'b1;
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle(input int n);
    DATA_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset();
    RESET = 1'b1; DATA_VALID = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1'b0;
  endtask

  // A row counts as newly presented when valid follows a cycle that was empty or acked.
  always @(negedge CLK) begin
    exp_t e;
    if (ROW_VALID && prev_consumed) begin
      if (q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_row: got %0h expected none", ROW_OUT);
      end else begin
        e = q.pop_front();
        chk("mon_row_out", ROW_OUT, e.row);
        chk("mon_row_index", 64'(ROW_INDEX), 64'(e.idx));
        chk("mon_frame_end", 64'(FRAME_END), 64'(e.fe));
        chk("mon_row_sum", 64'(ROW_SUM), 64'(e.sum));
      end
    end
    prev_consumed = !ROW_VALID || ROW_ACK || RESET;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb, rmax;
    @(posedge CLK); #1;
    do_reset();
    chk("rst_valid", 64'(ROW_VALID), 0);
    chk("rst_row_out", ROW_OUT, 0);
    chk("rst_index", 64'(ROW_INDEX), 0);
    chk("rst_frame_end", 64'(FRAME_END), 0);
    chk("rst_sum", 64'(ROW_SUM), 0);
    chk("rst_overrun", 64'(OVERRUN), 0);
    chk("rst_truncated", 64'(TRUNCATED), 0);

    // Single row, consumer always ready.
    ROW_ACK = 1'b1;
    expect_row(mk(1), 2'd0);
    send_row(mk(1), 1'b0);
    chk("t1_valid", 64'(ROW_VALID), 1);
    chk("t1_sum36", 64'(ROW_SUM), 36);
    idle(1);
    chk("t1_valid_drop", 64'(ROW_VALID), 0);
    idle(2);

    // Five rows back-to-back across a frame boundary.
    do_reset();
    ROW_ACK = 1'b1;
    for (int r = 0; r < 5; r++) begin
      expect_row(mk(16*r + 1), 2'(r % 4));
      send_row(mk(16*r + 1), 1'b0);
    end
    idle(3);
    chk("t2_overrun", 64'(OVERRUN), 0);

    // Overrun: second row dropped while the first is held.
    ROW_ACK = 1'b0;
    do_reset();
    ra = mk(100); rb = mk(40);
    expect_row(ra, 2'd0);
    send_row(ra, 1'b0);
    send_row(rb, 1'b0);
    chk("t3_overrun", 64'(OVERRUN), 1);
    chk("t3_valid_held", 64'(ROW_VALID), 1);
    chk("t3_row_held", ROW_OUT, ra);
    chk("t3_index_held", 64'(ROW_INDEX), 0);
    DATA_VALID = 1'b0; ROW_ACK = 1'b1;
    idle(1);
    chk("t3_ack_clears", 64'(ROW_VALID), 0);
    expect_row(mk(9), 2'd2);
    send_row(mk(9), 1'b0);
    chk("t3_next_index", 64'(ROW_INDEX), 2);
    idle(2);

    // Ack coinciding with completion of the next row.
    ROW_ACK = 1'b0;
    do_reset();
    expect_row(mk(20), 2'd0);
    send_row(mk(20), 1'b0);
    idle(2);
    expect_row(mk(50), 2'd1);
    send_row(mk(50), 1'b1);
    chk("t4_valid_stays", 64'(ROW_VALID), 1);
    chk("t4_new_row", ROW_OUT, mk(50));
    chk("t4_index", 64'(ROW_INDEX), 1);
    chk("t4_no_overrun", 64'(OVERRUN), 0);
    idle(2);

    // Truncated burst does not advance the row counter.
    do_reset();
    ROW_ACK = 1'b1;
    DATA_VALID = 1'b1; DATA_IN = 16'h0201;
    @(posedge CLK); #1;
    DATA_IN = 16'h0403;
    @(posedge CLK); #1;
    idle(1);
    chk("t5_truncated", 64'(TRUNCATED), 1);
    chk("t5_no_valid", 64'(ROW_VALID), 0);
    expect_row(mk(3), 2'd0);
    send_row(mk(3), 1'b0);
    chk("t5_index", 64'(ROW_INDEX), 0);
    chk("t5_sum", 64'(ROW_SUM), 52);
    idle(2);

    // Reset in the middle of a burst, with beats arriving during reset.
    DATA_VALID = 1'b1; DATA_IN = 16'h1111;
    @(posedge CLK); #1;
    RESET = 1'b1; DATA_IN = 16'h2222;
    @(posedge CLK); #1;
    DATA_IN = 16'h3333;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("t6_row_out", ROW_OUT, 0);
    chk("t6_truncated", 64'(TRUNCATED), 0);
    chk("t6_sum", 64'(ROW_SUM), 0);
    chk("t6_valid", 64'(ROW_VALID), 0);
    rmax = '1;
    expect_row(rmax, 2'd0);
    send_row(rmax, 1'b0);
    chk("t6_sum2040", 64'(ROW_SUM), 2040);
    chk("t6_index", 64'(ROW_INDEX), 0);
    idle(3);

    chk("queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
